// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder
//   Collapses PS/2 set-2 scancode bytes from ps2_rx into single key events.
//   E0 (extended) and F0 (break) prefixes are folded into flags. The 8-byte
//   E1 Pause sequence is swallowed. Controller/ack bytes are discarded.
//   Live modifier state is tracked. Events are buffered in a first-word
//   fall-through FIFO that the CPU side pops with ev_rd.
//
// Optional build macro: PS2_ASCII_EN
//   When defined, each event is translated through a set-2 -> ASCII table at
//   enqueue time. The result is stored with the FIFO entry.
//   When undefined, ev_ascii reads 00.
//
// Ports
//   clk      in   system clock, shared with ps2_rx
//   rst      in   asynchronous active-low reset
//   rda      in   byte ready from ps2_rx (edge-detected)
//   data     in   [7:0] scancode byte, valid while rda=1
//   ev_rd    in   pop strobe for the head event
//   ovf_clr  in   clears the sticky overflow flag
//   ev_valid out  FIFO not empty
//   ev_code  out  [7:0] head event base scancode
//   ev_ext   out  head event was E0-prefixed
//   ev_break out  head event is a key release
//   ev_ascii out  [7:0] head event ASCII code (00 without PS2_ASCII_EN)
//   mods     out  [3:0] live {alt, ctrl, rshift, lshift}
//   ovf      out  sticky: an event was dropped on a full FIFO
module ps2_kbd_decoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rda,
  input  logic [7:0] data,
  input  logic       ev_rd,
  input  logic       ovf_clr,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic [3:0] mods,
  output logic       ovf
);

`ifdef PS2_ASCII_EN
  localparam int unsigned EW = 18;  // {ascii, ext, brk, code}
`else
  localparam int unsigned EW = 10;  // {ext, brk, code}
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh);
    logic [7:0] a;
    logic       letter;
    a      = 8'h00;
    letter = 1'b1;
    case (c)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      if (sh) a = a - 8'h20;
    end else begin
      case (c)
        8'h16: a = sh ? 8'h21 : 8'h31;
        8'h1E: a = sh ? 8'h40 : 8'h32;
        8'h26: a = sh ? 8'h23 : 8'h33;
        8'h25: a = sh ? 8'h24 : 8'h34;
        8'h2E: a = sh ? 8'h25 : 8'h35;
        8'h36: a = sh ? 8'h5E : 8'h36;
        8'h3D: a = sh ? 8'h26 : 8'h37;
        8'h3E: a = sh ? 8'h2A : 8'h38;
        8'h46: a = sh ? 8'h28 : 8'h39;
        8'h45: a = sh ? 8'h29 : 8'h30;
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction
`endif

  // Byte capture
  logic rda_q;
  logic accept;

  assign accept = rda & ~rda_q;

  // Decoder state
  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [3:0]    mods_q, mods_d;
  logic          emit;
  logic          ext_d, brk_d;
  logic [EW-1:0] entry_d, entry_q;
  logic          pend_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    mods_d  = mods_q;
    emit    = 1'b0;
    ext_d   = 1'b0;
    brk_d   = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (data == 8'hE0)            state_d = S_EXT;
          else if (data == 8'hF0)       state_d = S_BRK;
          else if (data == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_discard(data)) emit = 1'b1;
        end
        S_EXT: begin
          if (data == 8'hF0)            state_d = S_EXT_BRK;
          else if (data == 8'hE0)       state_d = S_EXT;
          else if (data == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (is_discard(data)) state_d = S_IDLE;
          else begin
            emit    = 1'b1;
            ext_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (data == 8'hF0)             state_d = S_BRK;
          else if (data == 8'hE0)        state_d = S_EXT_BRK;
          else if (is_discard(data))     state_d = S_IDLE;
          else begin
            emit    = 1'b1;
            brk_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (data == 8'hF0 || data == 8'hE0) state_d = S_EXT_BRK;
          else if (is_discard(data))          state_d = S_IDLE;
          else begin
            emit    = 1'b1;
            ext_d   = 1'b1;
            brk_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Modifiers follow the decoded event, whether or not the FIFO keeps it.
    if (emit) begin
      case (data)
        8'h12: if (!ext_d) mods_d[0] = ~brk_d;
        8'h59: if (!ext_d) mods_d[1] = ~brk_d;
        8'h14: mods_d[2] = ~brk_d;
        8'h11: mods_d[3] = ~brk_d;
        default: ;
      endcase
    end

`ifdef PS2_ASCII_EN
    entry_d = {(emit && !ext_d && !brk_d) ? to_ascii(data, mods_q[0] | mods_q[1]) : 8'h00,
               ext_d, brk_d, data};
`else
    entry_d = {ext_d, brk_d, data};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda_q   <= 1'b0;
      state_q <= S_IDLE;
      skip_q  <= '0;
      mods_q  <= '0;
      pend_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      rda_q   <= rda;
      state_q <= state_d;
      skip_q  <= skip_d;
      mods_q  <= mods_d;
      pend_q  <= emit;
      entry_q <= entry_d;
    end
  end

  // Event FIFO
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, empty, rd_ok, wr_ok, drop;
  logic [EW-1:0] head;

  // DEPTH is 2**AW, so the count's top bit is set only when full.
  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign rd_ok = ev_rd & ~empty;
  assign wr_ok = pend_q & (~full | rd_ok);
  assign drop  = pend_q & full & ~rd_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (rd_ok && !wr_ok) cnt_q <= cnt_q - (AW+1)'(1);
      // A same-cycle drop overrides the clear.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= entry_q;
  end

  assign head     = mem_q[rd_ptr_q];
  assign ev_valid = ~empty;
  assign ev_code  = ev_valid ? head[7:0] : '0;
  assign ev_break = ev_valid & head[8];
  assign ev_ext   = ev_valid & head[9];
`ifdef PS2_ASCII_EN
  assign ev_ascii = ev_valid ? head[17:10] : '0;
`else
  assign ev_ascii = '0;
`endif
  assign mods     = mods_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
module tb_ps2_kbd_decoder;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, rda, ev_rd, ovf_clr;
  logic [7:0] data;
  logic       ev_valid, ev_ext, ev_break, ovf;
  logic [7:0] ev_code, ev_ascii;
  logic [3:0] mods;

  always #5 clk = ~clk;

  ps2_kbd_decoder #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst(rst), .rda(rda), .data(data), .ev_rd(ev_rd), .ovf_clr(ovf_clr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_ascii(ev_ascii), .mods(mods), .ovf(ovf)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};
  localparam logic [7:0] DIGSYM [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
    8'h2A, 8'h28, 8'h29};
  localparam logic [7:0] DISCARDS [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  localparam logic [7:0] MODKEYS [4] = '{8'h12, 8'h59, 8'h14, 8'h11};

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   auto_rd = 1'b0;
  bit   force_rd = 1'b0;

  // Reference model: pending prefix flags plus a count of Pause bytes still to swallow.
  bit        m_ext, m_brk, m_ovf;
  int        m_skip;
  logic [3:0] m_mods;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_discard(input logic [7:0] b);
    foreach (DISCARDS[i]) if (DISCARDS[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit sh);
`ifdef PS2_ASCII_EN
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == c) return sh ? DIGSYM[i] : ((i < 9) ? 8'h31 + 8'(i) : 8'h30);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
`else
    return (c & 8'h00) | {7'd0, sh & 1'b0};
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit sim_rd);
    ev_t e;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (b == 8'hE1 && !m_brk) begin
      m_skip = 7;
      m_ext  = 1'b0;
      return;
    end
    if (b == 8'hE0) begin m_ext = 1'b1; return; end
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    if (is_discard(b)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      return;
    end
    e.code  = b;
    e.ext   = m_ext;
    e.brk   = m_brk;
    e.ascii = (!m_ext && !m_brk) ? model_ascii(b, m_mods[0] | m_mods[1]) : 8'h00;
    if (exp_q.size() < DEPTH || sim_rd) exp_q.push_back(e);
    else m_ovf = 1'b1;
    if (b == 8'h12 && !m_ext) m_mods[0] = !m_brk;
    if (b == 8'h59 && !m_ext) m_mods[1] = !m_brk;
    if (b == 8'h14) m_mods[2] = !m_brk;
    if (b == 8'h11) m_mods[3] = !m_brk;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  // One byte from ps2_rx. hold = cycles rda stays high, gap = idle cycles after.
  // sim_rd pops in the cycle the event lands in the FIFO; clr pulses ovf_clr then too.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap,
                           input bit sim_rd = 1'b0, input bit clr = 1'b0);
    @(posedge clk); #1;
    data = b;
    rda  = 1'b1;
    if (clr) m_ovf = 1'b0;
    model_byte(b, sim_rd);
    @(posedge clk); #1;
    force_rd = sim_rd;
    ovf_clr  = clr;
    if (hold <= 1) begin
      rda  = 1'b0;
      data = 8'($urandom);
    end
    @(posedge clk); #1;
    force_rd = 1'b0;
    ovf_clr  = 1'b0;
    if (hold > 1) begin
      repeat (hold - 2) begin @(posedge clk); #1; end
      rda  = 1'b0;
      data = 8'($urandom);
    end
    repeat (gap) begin @(posedge clk); #1; end
    chk("mods", {28'd0, mods}, {28'd0, m_mods});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(1, 3), $urandom_range(2, 4));
  endtask

  task automatic drain();
    int n;
    auto_rd = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("drain_valid", {31'd0, ev_valid}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  // Monitor: pops the head whenever it chooses (or is told) to read, and scores it.
  initial begin
    ev_t e;
    ev_rd = 1'b0;
    forever begin
      @(negedge clk);
      ev_rd = 1'b0;
      if (rst === 1'b1 && ev_valid &&
          (force_rd || (auto_rd && $urandom_range(0, 2) != 0))) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {24'd0, ev_code}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("ev_code", {24'd0, ev_code}, {24'd0, e.code});
          chk("ev_ext", {31'd0, ev_ext}, {31'd0, e.ext});
          chk("ev_break", {31'd0, ev_break}, {31'd0, e.brk});
          chk("ev_ascii", {24'd0, ev_ascii}, {24'd0, e.ascii});
        end
        ev_rd = 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    rst = 1'b0; rda = 1'b0; data = 8'h00; ovf_clr = 1'b0;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_skip = 0; m_mods = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, ev_valid}, 32'd0);
    chk("rst_code", {24'd0, ev_code}, 32'd0);
    chk("rst_ext", {31'd0, ev_ext}, 32'd0);
    chk("rst_brk", {31'd0, ev_break}, 32'd0);
    chk("rst_ascii", {24'd0, ev_ascii}, 32'd0);
    chk("rst_mods", {28'd0, mods}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    auto_rd = 1'b1;

    // Single make, shifted letter, Ctrl-style extended keys, Pause, discards.
    send_seq('{8'h1C});
    drain();
    send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h1C});
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});
    send_seq('{8'hFA, 8'hAA, 8'h59, 8'h16, 8'hF0, 8'h59, 8'h16, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14});
    drain();

    // Reset in the middle of a break prefix.
    send_byte(8'hF0, 2, 3);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_mods = '0; m_ovf = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_valid", {31'd0, ev_valid}, 32'd0);
    rst = 1'b1;
    send_seq('{8'h1C});
    drain();

    // Overflow: 9 makes with no reads.
    auto_rd = 1'b0;
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44});
    chk("full_valid", {31'd0, ev_valid}, 32'd1);
    chk("full_head", {24'd0, ev_code}, 32'h15);
    chk("full_ovf", {31'd0, ovf}, 32'd1);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0; m_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    send_byte(8'h1C, 2, 3, 1'b1, 1'b0);   // write + read while full
    chk("sim_head", {24'd0, ev_code}, 32'h1D);
    send_byte(8'h1B, 2, 3, 1'b0, 1'b1);   // drop + clear in the same cycle
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0; m_ovf = 1'b0;
    chk("ovf_clr2", {31'd0, ovf}, 32'd0);
    drain();

    // Randomized byte stream.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'hE0;
      else if (r < 18) b = 8'hF0;
      else if (r < 20) b = 8'hE1;
      else if (r < 26) b = DISCARDS[$urandom_range(0, 7)];
      else if (r < 42) b = MODKEYS[$urandom_range(0, 3)];
      else if (r < 60) b = LETTERS[$urandom_range(0, 25)];
      else if (r < 72) b = DIGITS[$urandom_range(0, 9)];
      else             b = 8'($urandom);
      send_byte(b, $urandom_range(1, 4), $urandom_range(2, 5));
    end
    drain();
    chk("final_ovf", {31'd0, ovf}, {31'd0, m_ovf});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
